// File: rtl/seq_detect_fsm.sv
// Serial pattern detector with run-time overlapping/non-overlapping match and a registered match pulse.
// Defining SEQ_DET_COUNT_EN builds the saturating hit_count output and its counter.
module seq_detect_fsm #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       din,
   input  logic                       overlap,
   input  logic                       clear,
   output logic                       match,
   output logic [$clog2(PAT_W+1)-1:0] fill
`ifdef SEQ_DET_COUNT_EN
   ,
   output logic [CNT_W-1:0]           hit_count
`endif
);

   localparam int             FW        = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]  FILL_ARM  = FW'(PAT_W);
   localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_W - 1);

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_FILLING = 2'd1;
   localparam logic [1:0] ST_ARMED   = 2'd2;

   if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_cfg
      $error("seq_detect_fsm: PAT_W must be 2..32 and CNT_W at least 1");
   end

   // The oldest history bit is shifted out before it is ever compared, so only PAT_W-1 bits are kept.
   logic [PAT_W-2:0] hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             match_q, match_d;
   logic [1:0]       state;
   logic [PAT_W-1:0] shifted;
   logic             hit;

   always_comb begin
      if (fill_q == '0)            state = ST_EMPTY;
      else if (fill_q == FILL_ARM) state = ST_ARMED;
      else                         state = ST_FILLING;
   end

   assign shifted = {hist_q, din};
   assign hit     = en && !clear && ((state == ST_ARMED) || (fill_q == FILL_LAST))
                    && (shifted == PATTERN);

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      if (clear) begin
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         hist_d  = shifted[PAT_W-2:0];
         match_d = hit;
         if (hit && !overlap)      fill_d = '0;
         else if (state != ST_ARMED) fill_d = fill_q + FW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
      end
   end

   assign match = match_q;
   assign fill  = fill_q;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)                   cnt_d = '0;
      else if (hit && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign hit_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Self-checking bench for seq_detect_fsm: directed scenarios plus randomized traffic
// compared against a queue-based model of the qualified bit stream.
module tb_seq_detect_fsm;

   localparam int             PAT_W   = 4;
   localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
   localparam int             CNT_W   = 2;
   localparam int             FW      = $clog2(PAT_W + 1);
   localparam int             CNT_MAX = (1 << CNT_W) - 1;

   logic          clk = 1'b0;
   logic          reset, en, din, overlap, clear;
   logic          match;
   logic [FW-1:0] fill;
`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] hit_count;
`endif

   seq_detect_fsm #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .din      (din),
      .overlap  (overlap),
      .clear    (clear),
      .match    (match),
      .fill     (fill)
`ifdef SEQ_DET_COUNT_EN
      ,
      .hit_count(hit_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_match;

   // Reference model: the qualified bits received since the last restart point, newest last.
   bit               m_q[$];
   bit               m_match;
   int               m_cnt;
   logic [PAT_W-1:0] pat_v;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_match = 1'b0;
      m_cnt   = 0;
   endfunction

   function automatic void model_edge(input bit e, input bit d, input bit ov, input bit cl);
      bit hit;
      if (cl) begin
         model_reset();
      end else if (!e) begin
         m_match = 1'b0;
      end else begin
         m_q.push_back(d);
         if (m_q.size() > PAT_W) void'(m_q.pop_front());
         hit = (m_q.size() == PAT_W);
         for (int i = 0; i < PAT_W; i++)
            if (hit && m_q[i] != pat_v[PAT_W-1-i]) hit = 1'b0;
         m_match = hit;
         if (hit) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!ov) m_q.delete();
         end
      end
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_match"}, match, m_match);
      check({tag, "_fill"}, fill, m_q.size());
`ifdef SEQ_DET_COUNT_EN
      check({tag, "_count"}, hit_count, m_cnt);
`endif
   endtask

   task automatic step(input string tag, input bit e, input bit d, input bit ov, input bit cl);
      en = e; din = d; overlap = ov; clear = cl;
      @(posedge clk);
      model_edge(e, d, ov, cl);
      #1;
      check_outputs(tag);
      if (match === 1'b1) n_match++;
   endtask

   task automatic feed_bits(input string tag, input logic [31:0] bits, input int n, input bit ov);
      for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i], ov, 1'b0);
   endtask

   // Asynchronous reset asserted between edges, held for a number of clocks with din toggling.
   task automatic async_reset(input string tag, input int cycles);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_outputs({tag, "_async"});
      for (int i = 0; i < cycles; i++) begin
         en = 1'b1; din = i[0]; overlap = 1'b1; clear = 1'b0;
         @(posedge clk);
         #1;
         check_outputs({tag, "_hold"});
      end
      reset   = 1'b1;
      en      = 1'b0;
      n_match = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pat_v = PATTERN;
      reset = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b1; clear = 1'b0;
      model_reset();
      #1;
      check_outputs("por");

      // Reset hold, then fill ramps 1..PAT_W on qualified bits.
      @(posedge clk);
      #1;
      async_reset("rst", 2);
      for (int i = 0; i < PAT_W; i++) begin
         step("ramp", 1'b1, 1'b1, 1'b1, 1'b0);
         check("ramp_fill_abs", fill, i + 1);
      end

      async_reset("basic", 1);
      feed_bits("basic", 32'b1011, 4, 1'b1);
      check("basic_match_abs", match, 1);
      step("basic_after", 1'b0, 1'b0, 1'b1, 1'b0);
      check("basic_pulse_once", match, 0);

      async_reset("ovl", 1);
      feed_bits("ovl", 32'b1011011, 7, 1'b1);
      check("ovl_hits", n_match, 2);
`ifdef SEQ_DET_COUNT_EN
      check("ovl_count_abs", hit_count, 2);
`endif

      async_reset("novl", 1);
      feed_bits("novl", 32'b1011011, 7, 1'b0);
      check("novl_hits", n_match, 1);
      check("novl_fill_abs", fill, 3);

      async_reset("gap", 1);
      for (int i = 3; i >= 0; i--) begin
         step("gap_bit", 1'b1, pat_v[i], 1'b1, 1'b0);
         for (int g = 0; g < 3; g++) step("gap_idle", 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
      end
      check("gap_hits", n_match, 1);

      async_reset("clr", 1);
      feed_bits("clr", 32'b101, 3, 1'b1);
      step("clr_edge", 1'b1, 1'b1, 1'b1, 1'b1);
      step("clr_last", 1'b1, 1'b1, 1'b1, 1'b0);
      check("clr_no_hit", n_match, 0);
      check("clr_fill_abs", fill, 1);

      async_reset("sat", 1);
      begin
         logic [12:0] sat_bits;
         int          k;
         sat_bits = 13'b1011011011011;
         k = 0;
         for (int i = 12; i >= 0; i--) begin
            step("sat", 1'b1, sat_bits[i], 1'b1, 1'b0);
`ifdef SEQ_DET_COUNT_EN
            if (match === 1'b1) begin
               check("sat_count_abs", hit_count, (k < 3) ? k + 1 : 3);
               k++;
            end
`endif
         end
      end
      check("sat_hits", n_match, 4);

      // Mid-sequence asynchronous reset discards partial progress.
      async_reset("mid_pre", 1);
      feed_bits("mid", 32'b101, 3, 1'b1);
      async_reset("mid", 1);
      step("mid_after", 1'b1, 1'b1, 1'b1, 1'b0);
      check("mid_fill_abs", fill, 1);

      // Randomized traffic with run-time overlap changes, clears and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         bit e, d, ov, cl;
         e  = ($urandom_range(99) < 75);
         d  = ($urandom_range(99) < 65);
         ov = ($urandom_range(99) < 50);
         cl = ($urandom_range(99) < 3);
         if ($urandom_range(999) < 4) async_reset("rnd", $urandom_range(2));
         else step("rnd", e, d, ov, cl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
